// File: rtl/uart_frame_pkg.sv
// Shared framing definitions for the UART transmit framer and receive deframer.
// Contents: start/end marker bytes and the deframer state encoding.
// Both ends import this so the on-wire markers have exactly one definition.
package uart_frame_pkg;

  localparam logic [7:0] START_BYTE = 8'hAA;
  localparam logic [7:0] END_BYTE   = 8'hBB;

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    RD_BYTES = 2'd1,
    RD_END   = 2'd2,
    OUTPUT   = 2'd3
  } deframer_state_e;

endpackage

// File: rtl/data_deframer_if.sv
// Bus bundle between RX FIFO, deframer and downstream word consumer.
// Ports: FIFO head byte/empty/pop, assembled word with valid/ready, error pulse.
// master = deframer side, slave = environment (FIFO owner + consumer).
interface data_deframer_if #(
  parameter int NBYTES = 4
) ();

  logic [7:0]          uart_data_i;
  logic                uart_fifo_empty_i;
  logic                uart_rd_en_o;
  logic [8*NBYTES-1:0] data_o;
  logic                valid_o;
  logic                ready_i;
  logic                frame_err_o;

  modport master (
    input  uart_data_i, uart_fifo_empty_i, ready_i,
    output uart_rd_en_o, data_o, valid_o, frame_err_o
  );

  modport slave (
    output uart_data_i, uart_fifo_empty_i, ready_i,
    input  uart_rd_en_o, data_o, valid_o, frame_err_o
  );

endinterface

// File: rtl/data_deframer.sv
// Purpose: pops RX FIFO bytes, hunts for 0xAA, gathers NBYTES payload LSB-first, checks 0xBB.
// Latency: valid_o rises on the edge after the end byte is popped; one frame per NBYTES+3 cycles.
// Backpressure: while a word is held for downstream the FIFO is not popped at all.
// Ports: clk, rst (sync, active-high); bus (master) carries FIFO pop side,
//        data_o/valid_o/ready_i word output and the one-cycle frame_err_o pulse.
module data_deframer
  import uart_frame_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  data_deframer_if.master bus
);

  localparam int W  = 8 * NBYTES;
  localparam int CW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  deframer_state_e state_q, state_d;
  logic [CW-1:0]   byte_cnt_q, byte_cnt_d;
  logic [W-1:0]    shreg_q, shreg_d;
  logic [W-1:0]    data_q, data_d;
  logic            valid_q, valid_d;
  logic            frame_err_q, frame_err_d;
  logic            accept;

  // A byte is consumed whenever we pop; nothing is popped while a word is held.
  assign accept = !rst && !bus.uart_fifo_empty_i && (state_q != OUTPUT);

  assign bus.uart_rd_en_o = accept;
  assign bus.data_o       = data_q;
  assign bus.valid_o      = valid_q;
  assign bus.frame_err_o  = frame_err_q;

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    shreg_d     = shreg_q;
    data_d      = data_q;
    valid_d     = valid_q;
    frame_err_d = 1'b0;

    case (state_q)
      HUNT: begin
        if (accept && (bus.uart_data_i == START_BYTE)) begin
          state_d    = RD_BYTES;
          byte_cnt_d = '0;
        end
      end

      RD_BYTES: begin
        if (accept) begin
          // Shift in from the top so the first payload byte ends up in bits [7:0].
          shreg_d    = (shreg_q >> 8) | (W'(bus.uart_data_i) << (W - 8));
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (byte_cnt_q == CW'(NBYTES - 1)) begin
            state_d = RD_END;
          end
        end
      end

      RD_END: begin
        if (accept) begin
          if (bus.uart_data_i == END_BYTE) begin
            state_d = OUTPUT;
            data_d  = shreg_q;
            valid_d = 1'b1;
          end else begin
            // The bad byte is consumed even if it is 0xAA: no resync on it.
            state_d     = HUNT;
            frame_err_d = 1'b1;
          end
        end
      end

      OUTPUT: begin
        if (valid_q && bus.ready_i) begin
          valid_d = 1'b0;
          state_d = HUNT;
        end
      end

      default: begin
        state_d = HUNT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= HUNT;
      byte_cnt_q  <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      shreg_q     <= shreg_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
    end
  end

endmodule
